vga_pixel_pipeline: RTL and testbench
=====================================

Name: vga_pixel_pipeline

Overview:
- Parametrised VGA display engine that replaces the fixed-timing VGA top plus divider pairing.
- Generates the pixel-clock enable internally and owns the sync and blanking timing.
- Publishes pixel coordinates to an external pixel source with a known latency, realigns sync and blank to the returned colour, and drives registered RGB.
- Adds built-in test-pattern modes, switched only at frame boundaries.

Parameters:
- CLK_DIV, 4: system clocks per pixel tick (>=1; 4 gives 25 MHz from 100 MHz).
- COLOR_W, 4: bits per colour channel.
- H_ACTIVE, 640: visible pixels per line (multiple of 8).
- H_FP, 16: horizontal front porch in pixels.
- H_SYNC, 96: hsync width in pixels.
- H_BP, 48: horizontal back porch in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch in lines.
- V_SYNC, 2: vsync width in lines.
- V_BP, 33: vertical back porch in lines.
- SYNC_POL, 0: sync active level (0 = active-low, idle high).
- PIPE_LAT, 2: pixel ticks from coordinate publish to colour valid on in_r/g/b (0..8).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active-low.
- mode  input  2  0 pass-through, 1 solid white, 2 colour bars, 3 black.
- in_r  input  COLOR_W  pixel-source red.
- in_g  input  COLOR_W  pixel-source green.
- in_b  input  COLOR_W  pixel-source blue.
- pix_en  output  1  one-clk pixel tick strobe.
- pixel_x  output  clog2(H_TOTAL)  current h counter.
- pixel_y  output  clog2(V_TOTAL)  current v counter.
- pixel_req  output  1  h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- frame_start  output  1  one-clk pulse at start of frame.
- vga_r  output  COLOR_W  registered red.
- vga_g  output  COLOR_W  registered green.
- vga_b  output  COLOR_W  registered blue.
- h_sync  output  1  registered hsync.
- v_sync  output  1  registered vsync.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 every clk, wrapping to 0.
  - pix_en=1 while div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_en constantly high.
- Counters (advance only on pix_en):
  - h_cnt wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
- pixel_x/pixel_y are the counter registers themselves; pixel_req is combinational from them.
- Raw sync: hs_raw active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs_raw uses the same rule on v_cnt.
- frame_start = pix_en & h_cnt==0 & v_cnt==0.
- Mode latch: mode_q samples mode only on a frame_start clk, so a mode change never tears mid-frame.
- Alignment:
  - hs_raw, vs_raw, pixel_req and bar index pass through a PIPE_LAT-stage delay line, shifting on pix_en only.
  - bar_idx = floor(h_cnt/(H_ACTIVE/8)), 3 bits.
- Output stage (updates on pix_en only):
  - h_sync/v_sync = delayed raw sync mapped to SYNC_POL.
  - If the delayed active flag is 0: RGB = 0.
  - Otherwise select by mode_q: 0 in_*; 1 all-ones; 2 bars; 3 zero.
  - Bar order 0..7: white, yellow, cyan, green, magenta, red, blue, black (all-ones/zero per channel).
- Latency: outputs reflect counter state PIPE_LAT+1 pixel ticks earlier. With PIPE_LAT=0, in_* is sampled on the same pix_en as its coordinate.
- Reset (async assert, async release):
  - div_cnt, h_cnt, v_cnt and mode_q go to 0.
  - Delay lines go to inactive/idle.
  - vga_* = 0; h_sync = v_sync = idle level (~SYNC_POL).
  - Reset mid-frame aborts the frame. After release the first frame starts at (0,0): frame_start is asserted on the first pix_en after release.
- Outputs hold between pix_en strobes.

Test Plan:
- Common setup: H=8/2/3/2 (H_TOTAL 15), V=4/1/1/1 (V_TOTAL 7), CLK_DIV=2, PIPE_LAT=2, SYNC_POL=0.
- Reset check: hold reset=0 -> vga_*=0, h_sync=v_sync=1, pix_en=0. Release -> pix_en high every 2nd clk; pixel_x sequence 0..14,0; frame_start on the first pix_en and then every 105 ticks.
- Sync timing: count ticks -> h_sync low for exactly 3 ticks, starting PIPE_LAT+1=3 ticks after pixel_x==10; v_sync low for exactly 15 ticks (one line) in line 5, shifted by 3 ticks.
- Pass-through alignment, mode=0: model returns in_r=pixel_x delayed 2 ticks -> vga_r == x for x=0..7 on visible lines, and 0 during blanking (including the in_r value presented at x=8..14).
- Colour bars and mode timing: mode=2 applied mid-frame -> no change until the next frame_start. Then with H_ACTIVE=8 each bar is one pixel: RGB sequence F/F/F, F/F/0, 0/F/F, 0/F/0, F/0/F, F/0/0, 0/0/F, 0/0/0.
- Mid-frame reset: assert reset at pixel (5,2) -> outputs immediately at reset values. After release, frame restarts at (0,0) with frame_start; mode_q returns to 0.
- Divider corner: CLK_DIV=1, PIPE_LAT=0 -> pix_en constantly 1; vga_r follows in_r with 1-clk latency; h_sync period 15 clks.

Source files
------------

// File: rtl/vga_pixel_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_pixel_pipeline: VGA timing, pixel-source realignment, test patterns  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module vga_pixel_pipeline #(
   parameter int CLK_DIV  = 4,
   parameter int COLOR_W  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int PIPE_LAT = 2,
   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int c_X_W     = $clog2(c_H_TOTAL),
   localparam int c_Y_W     = $clog2(c_V_TOTAL)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         mode,
   input  logic [COLOR_W-1:0] in_r,
   input  logic [COLOR_W-1:0] in_g,
   input  logic [COLOR_W-1:0] in_b,
   output logic               pix_en,
   output logic [c_X_W-1:0]   pixel_x,
   output logic [c_Y_W-1:0]   pixel_y,
   output logic               pixel_req,
   output logic               frame_start,
   output logic [COLOR_W-1:0] vga_r,
   output logic [COLOR_W-1:0] vga_g,
   output logic [COLOR_W-1:0] vga_b,
   output logic               h_sync,
   output logic               v_sync
);

   localparam int   c_DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int   c_BAR_W     = H_ACTIVE / 8;
   localparam logic c_SYNC_IDLE = (SYNC_POL == 0) ? 1'b1 : 1'b0;
   localparam logic c_SYNC_ACT  = ~c_SYNC_IDLE;

   logic               w_pix_en;
   logic [c_X_W-1:0]   r_h_cnt;
   logic [c_Y_W-1:0]   r_v_cnt;
   logic [31:0]        w_h32;
   logic [31:0]        w_v32;
   logic               w_hs_raw;
   logic               w_vs_raw;
   logic               w_req;
   logic [2:0]         w_bar_idx;
   logic [5:0]         w_raw;
   logic [5:0]         w_dly;
   logic               w_frame_start;
   logic [1:0]         r_mode_q;
   logic [COLOR_W-1:0] w_r, w_g, w_b;
   logic [COLOR_W-1:0] r_vga_r, r_vga_g, r_vga_b;
   logic               r_h_sync, r_v_sync;

   generate
      if (CLK_DIV > 1) begin : g_div
         logic [c_DIV_W-1:0] r_div_cnt;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               r_div_cnt <= '0;
            else if (r_div_cnt == c_DIV_W'(CLK_DIV - 1))
               r_div_cnt <= '0;
            else
               r_div_cnt <= r_div_cnt + c_DIV_W'(1);
         end
         assign w_pix_en = (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
      end else begin : g_nodiv
         assign w_pix_en = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_pix_en) begin
         if (r_h_cnt == c_X_W'(c_H_TOTAL - 1)) begin
            r_h_cnt <= '0;
            if (r_v_cnt == c_Y_W'(c_V_TOTAL - 1))
               r_v_cnt <= '0;
            else
               r_v_cnt <= r_v_cnt + c_Y_W'(1);
         end else begin
            r_h_cnt <= r_h_cnt + c_X_W'(1);
         end
      end
   end

   assign w_h32    = 32'(r_h_cnt);
   assign w_v32    = 32'(r_v_cnt);
   assign w_req    = (w_h32 < 32'(H_ACTIVE)) && (w_v32 < 32'(V_ACTIVE));
   assign w_hs_raw = (w_h32 >= 32'(H_ACTIVE + H_FP)) && (w_h32 < 32'(H_ACTIVE + H_FP + H_SYNC));
   assign w_vs_raw = (w_v32 >= 32'(V_ACTIVE + V_FP)) && (w_v32 < 32'(V_ACTIVE + V_FP + V_SYNC));

   // Threshold ladder instead of a divider; index is only meaningful while active.
   always_comb begin
      w_bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (w_h32 >= 32'(k * c_BAR_W))
            w_bar_idx = 3'(k);
      end
   end

   assign w_raw = {w_bar_idx, w_req, w_vs_raw, w_hs_raw};

   generate
      if (PIPE_LAT == 0) begin : g_nodly
         assign w_dly = w_raw;
      end else begin : g_dly
         logic [5:0] r_dly [PIPE_LAT];
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < PIPE_LAT; i++)
                  r_dly[i] <= '0;
            end else if (w_pix_en) begin
               r_dly[0] <= w_raw;
               for (int i = 1; i < PIPE_LAT; i++)
                  r_dly[i] <= r_dly[i-1];
            end
         end
         assign w_dly = r_dly[PIPE_LAT-1];
      end
   endgenerate

   assign w_frame_start = w_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_mode_q <= 2'd0;
      else if (w_frame_start)
         r_mode_q <= mode;
   end

   // Bar colour bits: red off for bars 2,3,6,7; green off for 4..7; blue on for even bars.
   always_comb begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
      if (w_dly[2]) begin
         case (r_mode_q)
            2'd0: begin
               w_r = in_r;
               w_g = in_g;
               w_b = in_b;
            end
            2'd1: begin
               w_r = {COLOR_W{1'b1}};
               w_g = {COLOR_W{1'b1}};
               w_b = {COLOR_W{1'b1}};
            end
            2'd2: begin
               w_r = {COLOR_W{~w_dly[4]}};
               w_g = {COLOR_W{~w_dly[5]}};
               w_b = {COLOR_W{~w_dly[3]}};
            end
            default: begin
               w_r = '0;
               w_g = '0;
               w_b = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vga_r  <= '0;
         r_vga_g  <= '0;
         r_vga_b  <= '0;
         r_h_sync <= c_SYNC_IDLE;
         r_v_sync <= c_SYNC_IDLE;
      end else if (w_pix_en) begin
         r_vga_r  <= w_r;
         r_vga_g  <= w_g;
         r_vga_b  <= w_b;
         r_h_sync <= w_dly[0] ? c_SYNC_ACT : c_SYNC_IDLE;
         r_v_sync <= w_dly[1] ? c_SYNC_ACT : c_SYNC_IDLE;
      end
   end

   assign pix_en      = w_pix_en;
   assign pixel_x     = r_h_cnt;
   assign pixel_y     = r_v_cnt;
   assign pixel_req   = w_req;
   assign frame_start = w_frame_start;
   assign vga_r       = r_vga_r;
   assign vga_g       = r_vga_g;
   assign vga_b       = r_vga_b;
   assign h_sync      = r_h_sync;
   assign v_sync      = r_v_sync;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_pipeline.sv
`default_nettype none
// Scoreboard bench: A = divided clock with 2-tick source latency, B = undivided, zero latency.
module tb_vga_pixel_pipeline;

   typedef struct {
      int         x;
      int         y;
      logic       fs;
      logic       hs;
      logic       vs;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a = 1'b0;
   logic       reset_b = 1'b0;
   logic [1:0] mode_a  = 2'd0;
   logic [1:0] mode_b  = 2'd0;
   logic [3:0] in_r_b  = 4'h0;
   logic [3:0] in_g_b  = 4'h0;
   logic [3:0] in_b_b  = 4'hF;
   wire  [3:0] in_r_a, in_g_a, in_b_a;

   wire        pix_en_a, req_a, fs_a, hs_a, vs_a;
   wire  [3:0] px_a, vr_a, vg_a, vb_a;
   wire  [2:0] py_a;
   wire        pix_en_b, req_b, fs_b, hs_b, vs_b;
   wire  [3:0] px_b, vr_b, vg_b, vb_b;
   wire  [2:0] py_b;

   vga_pixel_pipeline #(
      .CLK_DIV(2), .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .PIPE_LAT(2)
   ) dut_a (
      .clk(clk), .reset(reset_a), .mode(mode_a),
      .in_r(in_r_a), .in_g(in_g_a), .in_b(in_b_a),
      .pix_en(pix_en_a), .pixel_x(px_a), .pixel_y(py_a), .pixel_req(req_a),
      .frame_start(fs_a), .vga_r(vr_a), .vga_g(vg_a), .vga_b(vb_a),
      .h_sync(hs_a), .v_sync(vs_a)
   );

   vga_pixel_pipeline #(
      .CLK_DIV(1), .COLOR_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .PIPE_LAT(0)
   ) dut_b (
      .clk(clk), .reset(reset_b), .mode(mode_b),
      .in_r(in_r_b), .in_g(in_g_b), .in_b(in_b_b),
      .pix_en(pix_en_b), .pixel_x(px_b), .pixel_y(py_b), .pixel_req(req_b),
      .frame_start(fs_b), .vga_r(vr_b), .vga_g(vg_b), .vga_b(vb_b),
      .h_sync(hs_b), .v_sync(vs_b)
   );

   // Pixel source for A: returns colour for a coordinate two pixel ticks later.
   logic [3:0] src_d1 = 4'h0;
   logic [3:0] src_d2 = 4'h0;
   always @(posedge clk) begin
      if (pix_en_a) begin
         src_d1 <= px_a;
         src_d2 <= src_d1;
      end
   end
   assign in_r_a = src_d2;
   assign in_g_a = ~src_d2;
   assign in_b_a = 4'h9;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   bit   mon_a_en = 1'b0;
   bit   mon_b_en = 1'b0;
   bit   first_a  = 1'b1;
   int   gap_a    = 0;
   int   ticks_a  = 0;
   int   ticks_b  = 0;

   // white, yellow, cyan, green, magenta, red, blue, black as {r,g,b}
   logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

   task automatic check(string name, int at, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0d: got %0h expected %0h", name, at, act, exp);
      end
   endtask

   function automatic logic [3:0] pat(int n);
      return 4'((n * 5 + 3) & 15);
   endfunction

   // Expected A outputs during pixel tick k; mode input switches to newm at tick chg (-1: never).
   function automatic exp_t exp_a(int k, int chg, int newm);
      exp_t e;
      int j, xj, yj, f, m;
      e.x  = k % 15;
      e.y  = (k / 15) % 7;
      e.fs = (e.x == 0) && (e.y == 0);
      e.hs = 1'b1; e.vs = 1'b1;
      e.r  = 4'h0; e.g = 4'h0; e.b = 4'h0;
      if (k >= 3) begin
         j  = k - 3;
         xj = j % 15;
         yj = (j / 15) % 7;
         e.hs = !(xj >= 10 && xj <= 12);
         e.vs = (yj != 5);
         f = ((k - 2) / 105) * 105;
         m = (chg >= 0 && f >= chg) ? newm : 0;
         if (xj < 8 && yj < 4) begin
            if (m == 0) begin
               e.r = 4'(xj); e.g = ~4'(xj); e.b = 4'h9;
            end else if (m == 2) begin
               e.r = {4{bar_tab[xj][2]}};
               e.g = {4{bar_tab[xj][1]}};
               e.b = {4{bar_tab[xj][0]}};
            end
         end
      end
      return e;
   endfunction

   // Expected B outputs m clocks after release: reflect coordinate and input one clock earlier.
   function automatic exp_t exp_b(int m);
      exp_t e;
      int xj, yj;
      e.x  = m % 15;
      e.y  = (m / 15) % 7;
      e.fs = (e.x == 0) && (e.y == 0);
      xj = (m - 1) % 15;
      yj = ((m - 1) / 15) % 7;
      e.hs = !(xj >= 10 && xj <= 12);
      e.vs = (yj != 5);
      if (xj < 8 && yj < 4) begin
         e.r = pat(m - 1); e.g = 4'h0; e.b = 4'hF;
      end else begin
         e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
      end
      return e;
   endfunction

   task automatic cmp_exp(string tag, int at, exp_t e, logic [3:0] x, logic [2:0] y, logic fs,
                          logic hs, logic vs, logic [3:0] r, logic [3:0] g, logic [3:0] b);
      check({tag, "_x"},  at, 32'(x),  32'(e.x));
      check({tag, "_y"},  at, 32'(y),  32'(e.y));
      check({tag, "_fs"}, at, 32'(fs), 32'(e.fs));
      check({tag, "_hs"}, at, 32'(hs), 32'(e.hs));
      check({tag, "_vs"}, at, 32'(vs), 32'(e.vs));
      check({tag, "_r"},  at, 32'(r),  32'(e.r));
      check({tag, "_g"},  at, 32'(g),  32'(e.g));
      check({tag, "_b"},  at, 32'(b),  32'(e.b));
   endtask

   initial begin : mon_a
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_a_en) begin
            gap_a++;
            if (pix_en_a) begin
               if (!first_a) check("a_pix_gap", ticks_a, 32'(gap_a), 32'd2);
               first_a = 1'b0;
               gap_a   = 0;
               if (q_a.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL a_extra_tick at %0d: got tick expected none", ticks_a);
               end else begin
                  e = q_a.pop_front();
                  cmp_exp("a", ticks_a, e, px_a, py_a, fs_a, hs_a, vs_a, vr_a, vg_a, vb_a);
               end
               ticks_a++;
            end else begin
               check("a_fs_idle", ticks_a, 32'(fs_a), 32'd0);
            end
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_b_en) begin
            check("b_pix_en", ticks_b, 32'(pix_en_b), 32'd1);
            if (q_b.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL b_extra_clk at %0d: got clk expected none", ticks_b);
            end else begin
               e = q_b.pop_front();
               cmp_exp("b", ticks_b + 1, e, px_b, py_b, fs_b, hs_b, vs_b, vr_b, vg_b, vb_b);
            end
            ticks_b++;
         end
      end
   end

   task automatic wait_ticks_a(int n, int budget);
      int c = 0;
      while (ticks_a < n && c < budget) begin
         @(negedge clk); #2;
         c++;
      end
      if (ticks_a < n) begin
         n_cmp++; n_fail++;
         $display("FAIL a_tick_timeout: got %0d ticks expected %0d", ticks_a, n);
      end
   endtask

   task automatic wait_empty(bit which_b, int budget);
      int c = 0;
      while (((which_b ? q_b.size() : q_a.size()) != 0) && c < budget) begin
         @(negedge clk); #2;
         c++;
      end
      if ((which_b ? q_b.size() : q_a.size()) != 0) begin
         n_cmp++; n_fail++;
         $display("FAIL drain_timeout_%s: got %0d left expected 0", which_b ? "b" : "a",
                  which_b ? q_b.size() : q_a.size());
      end
   endtask

   task automatic check_reset_a(string tag);
      check({tag, "_pix_en"}, 0, 32'(pix_en_a), 32'd0);
      check({tag, "_r"},      0, 32'(vr_a),     32'd0);
      check({tag, "_g"},      0, 32'(vg_a),     32'd0);
      check({tag, "_b"},      0, 32'(vb_a),     32'd0);
      check({tag, "_hs"},     0, 32'(hs_a),     32'd1);
      check({tag, "_vs"},     0, 32'(vs_a),     32'd1);
      check({tag, "_x"},      0, 32'(px_a),     32'd0);
      check({tag, "_y"},      0, 32'(py_a),     32'd0);
   endtask

   initial begin : stim
      repeat (3) @(negedge clk);
      #1;
      check_reset_a("rst_a");
      check("rst_b_r",  0, 32'(vr_b), 32'd0);
      check("rst_b_hs", 0, 32'(hs_b), 32'd1);
      check("rst_b_vs", 0, 32'(vs_b), 32'd1);

      // Run A through two full frames into frame 2; mode 2 requested mid frame 0.
      for (int k = 0; k <= 245; k++) q_a.push_back(exp_a(k, 50, 2));
      @(negedge clk); #2;
      first_a = 1'b1; gap_a = 0; ticks_a = 0;
      reset_a = 1'b1;
      mon_a_en = 1'b1;
      wait_ticks_a(50, 400);
      mode_a = 2'd2;
      wait_empty(1'b0, 1000);

      // Now at pixel (5,2) of frame 2: abort the frame.
      reset_a = 1'b0;
      mon_a_en = 1'b0;
      #1;
      check_reset_a("midrst_a");
      mode_a = 2'd0;
      repeat (2) @(negedge clk);
      for (int k = 0; k <= 44; k++) q_a.push_back(exp_a(k, -1, 0));
      #2;
      first_a = 1'b1; gap_a = 0; ticks_a = 0;
      reset_a = 1'b1;
      mon_a_en = 1'b1;
      wait_empty(1'b0, 400);
      mon_a_en = 1'b0;
      reset_a = 1'b0;

      // Undivided, zero-latency instance.
      for (int m = 1; m <= 120; m++) q_b.push_back(exp_b(m));
      @(negedge clk); #1;
      ticks_b = 0;
      reset_b = 1'b1;
      in_r_b = pat(0);
      mon_b_en = 1'b1;
      for (int m = 1; m < 120; m++) begin
         @(negedge clk); #1;
         in_r_b = pat(m);
      end
      wait_empty(1'b1, 50);
      mon_b_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
